// File: rtl/mem_stage_pkg.sv
// MEM stage shared types and defaults.
// Optional MEM_ALIGN_CHECK_EN enables misaligned-access trapping.
package mem_stage_pkg;

  localparam int DW_DEF       = 32;
  localparam int RW_W_DEF     = 5;
  localparam int MAX_WAIT_DEF = 15;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic is_mem(
    input logic wr,
    input logic ld
  );
    return wr | ld;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: negedge update, sync reset, load enable.
// Ports: clk, rst, load, d_* next payload, q_* registered payload.
import mem_stage_pkg::*;

module mem_wb_reg #(
  parameter int DW   = DW_DEF,
  parameter int RW_W = RW_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            d_valid,
  input  logic            d_RegWr,
  input  logic [RW_W-1:0] d_rw,
  input  logic [DW-1:0]   d_data,
  input  logic            d_err,
  output logic            q_valid,
  output logic            q_RegWr,
  output logic [RW_W-1:0] q_rw,
  output logic [DW-1:0]   q_data,
  output logic            q_err
);

  always_ff @(negedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_RegWr <= 1'b0;
      q_rw    <= '0;
      q_data  <= '0;
      q_err   <= 1'b0;
    end else if (load) begin
      q_valid <= d_valid;
      q_RegWr <= d_RegWr;
      q_rw    <= d_rw;
      q_data  <= d_data;
      q_err   <= d_err;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory req/ack handshake, stall, timeout, MEM/WB reg.
// Ports: EX/MEM in_*, stall, dm_* memory bus, wb_* MEM/WB outputs.
// Option MEM_ALIGN_CHECK_EN: misaligned memory ops abort with wb_err.
import mem_stage_pkg::*;

module mem_stage #(
  parameter int DW       = DW_DEF,
  parameter int RW_W     = RW_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_result,
  input  logic [DW-1:0]   in_busB,
  input  logic [RW_W-1:0] in_rw,
  input  logic            in_RegWr,
  input  logic            in_MemWr,
  input  logic            in_MemtoReg,
  output logic            stall,
  output logic            dm_req,
  output logic            dm_we,
  output logic [DW-1:0]   dm_addr,
  output logic [DW-1:0]   dm_wdata,
  input  logic [DW-1:0]   dm_rdata,
  input  logic            dm_ack,
  output logic            wb_valid,
  output logic            wb_RegWr,
  output logic [RW_W-1:0] wb_rw,
  output logic [DW-1:0]   wb_data,
  output logic            wb_err
);

  localparam int CW = $clog2(MAX_WAIT) + 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            lat_load, lat_RegWr;
  logic [RW_W-1:0] lat_rw;
  logic [DW-1:0]   lat_result;

  logic            mem_op, misaligned, issue;
  logic [DW-1:0]   addr_al;
  logic            req_nxt, we_nxt;
  logic [DW-1:0]   addr_nxt, wdata_nxt;

  logic            wb_load, nxt_valid, nxt_RegWr, nxt_err;
  logic [RW_W-1:0] nxt_rw;
  logic [DW-1:0]   nxt_data;

  assign mem_op = is_mem(in_MemWr, in_MemtoReg);
  assign stall  = (state == WAIT);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (in_result[1:0] != 2'b00);
  assign addr_al    = in_result;
`else
  assign misaligned = 1'b0;
  assign addr_al    = {in_result[DW-1:2], 2'b00};
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    req_nxt   = dm_req;
    we_nxt    = dm_we;
    addr_nxt  = dm_addr;
    wdata_nxt = dm_wdata;
    wb_load   = 1'b0;
    nxt_valid = 1'b0;
    nxt_RegWr = 1'b0;
    nxt_rw    = '0;
    nxt_data  = '0;
    nxt_err   = 1'b0;
    unique case (state)
      IDLE: begin
        wb_load = 1'b1;
        cnt_nxt = '0;
        unique case (1'b1)
          !in_valid: ;
          in_valid && !mem_op: begin
            nxt_valid = 1'b1;
            nxt_RegWr = in_RegWr;
            nxt_rw    = in_rw;
            nxt_data  = in_result;
          end
          in_valid && mem_op && misaligned: begin
            nxt_valid = 1'b1;
            nxt_err   = 1'b1;
            nxt_rw    = in_rw;
            nxt_data  = in_result;
          end
          in_valid && mem_op && !misaligned: begin
            issue     = 1'b1;
            state_nxt = WAIT;
            req_nxt   = 1'b1;
            we_nxt    = in_MemWr;
            addr_nxt  = addr_al;
            wdata_nxt = in_busB;
          end
        endcase
      end
      WAIT: begin
        if (dm_ack) begin
          // ack beats a simultaneous timeout
          wb_load   = 1'b1;
          nxt_valid = 1'b1;
          nxt_RegWr = lat_RegWr;
          nxt_rw    = lat_rw;
          nxt_data  = lat_load ? dm_rdata : lat_result;
          req_nxt   = 1'b0;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(MAX_WAIT - 1)) begin
          wb_load   = 1'b1;
          nxt_valid = 1'b1;
          nxt_err   = 1'b1;
          nxt_rw    = lat_rw;
          nxt_data  = lat_result;
          req_nxt   = 1'b0;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      lat_load   <= 1'b0;
      lat_RegWr  <= 1'b0;
      lat_rw     <= '0;
      lat_result <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dm_req   <= req_nxt;
      dm_we    <= we_nxt;
      dm_addr  <= addr_nxt;
      dm_wdata <= wdata_nxt;
      if (issue) begin
        lat_load   <= in_MemtoReg;
        // stores never write back
        lat_RegWr  <= in_RegWr & in_MemtoReg;
        lat_rw     <= in_rw;
        lat_result <= in_result;
      end
    end
  end

  mem_wb_reg #(
    .DW   (DW),
    .RW_W (RW_W)
  ) u_mem_wb_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (wb_load),
    .d_valid (nxt_valid),
    .d_RegWr (nxt_RegWr),
    .d_rw    (nxt_rw),
    .d_data  (nxt_data),
    .d_err   (nxt_err),
    .q_valid (wb_valid),
    .q_RegWr (wb_RegWr),
    .q_rw    (wb_rw),
    .q_data  (wb_data),
    .q_err   (wb_err)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random transactions
// checked against a transaction-level model.
module tb_mem_stage;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_result;
  logic [31:0] in_busB;
  logic [4:0]  in_rw;
  logic        in_RegWr;
  logic        in_MemWr;
  logic        in_MemtoReg;
  logic        stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        wb_valid;
  logic        wb_RegWr;
  logic [4:0]  wb_rw;
  logic [31:0] wb_data;
  logic        wb_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(
    .DW       (32),
    .RW_W     (5),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_result   (in_result),
    .in_busB     (in_busB),
    .in_rw       (in_rw),
    .in_RegWr    (in_RegWr),
    .in_MemWr    (in_MemWr),
    .in_MemtoReg (in_MemtoReg),
    .stall       (stall),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_ack      (dm_ack),
    .wb_valid    (wb_valid),
    .wb_RegWr    (wb_RegWr),
    .wb_rw       (wb_rw),
    .wb_data     (wb_data),
    .wb_err      (wb_err)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // active edge is negedge; settle 1 time unit after it
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // kind: 0 bubble, 1 alu, 2 load, 3 store
  // n: cycle in WAIT carrying dm_ack; n > MAXW means never acked
  task automatic run_op(
    input int          kind,
    input logic [31:0] res,
    input logic [31:0] busb,
    input logic [4:0]  rw,
    input logic        regwr,
    input int          n,
    input logic [31:0] rdata
  );
    logic        ld, st, mis, to;
    logic [31:0] addr;
    int          last;
    ld = (kind == 2);
    st = (kind == 3);
    in_valid    = (kind != 0);
    in_MemtoReg = ld;
    in_MemWr    = st;
    in_result   = res;
    in_busB     = busb;
    in_rw       = rw;
    in_RegWr    = regwr;
    dm_ack      = 1'($urandom_range(0, 1));
    dm_rdata    = $urandom;
    check("idle_stall", {63'd0, stall}, 64'd0);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    mis = (res[1:0] != 2'b00);
    addr = res;
`else
    mis = 1'b0;
    addr = {res[31:2], 2'b00};
`endif
    if (kind == 0) begin
      check("bub_valid", {63'd0, wb_valid}, 64'd0);
      check("bub_regwr", {63'd0, wb_RegWr}, 64'd0);
      check("bub_req", {63'd0, dm_req}, 64'd0);
    end else if (kind == 1) begin
      check("alu_valid", {63'd0, wb_valid}, 64'd1);
      check("alu_regwr", {63'd0, wb_RegWr}, {63'd0, regwr});
      check("alu_rw", {59'd0, wb_rw}, {59'd0, rw});
      check("alu_data", {32'd0, wb_data}, {32'd0, res});
      check("alu_err", {63'd0, wb_err}, 64'd0);
      check("alu_stall", {63'd0, stall}, 64'd0);
    end else if (mis) begin
      check("mis_valid", {63'd0, wb_valid}, 64'd1);
      check("mis_err", {63'd0, wb_err}, 64'd1);
      check("mis_regwr", {63'd0, wb_RegWr}, 64'd0);
      check("mis_req", {63'd0, dm_req}, 64'd0);
      check("mis_stall", {63'd0, stall}, 64'd0);
    end else begin
      check("iss_we", {63'd0, dm_we}, {63'd0, st});
      if (st)
        check("iss_wdata", {32'd0, dm_wdata}, {32'd0, busb});
      last = (n > MAXW) ? MAXW : n;
      for (int k = 1; k <= last; k++) begin
        check("wait_stall", {63'd0, stall}, 64'd1);
        check("wait_req", {63'd0, dm_req}, 64'd1);
        check("wait_addr", {32'd0, dm_addr}, {32'd0, addr});
        check("wait_wbv", {63'd0, wb_valid}, 64'd0);
        dm_ack   = (k == n);
        dm_rdata = (k == n) ? rdata : $urandom;
        tick();
      end
      dm_ack = 1'b0;
      to = (n > MAXW);
      check("done_req", {63'd0, dm_req}, 64'd0);
      check("done_stall", {63'd0, stall}, 64'd0);
      check("done_valid", {63'd0, wb_valid}, 64'd1);
      check("done_err", {63'd0, wb_err}, {63'd0, to});
      check("done_regwr", {63'd0, wb_RegWr},
            {63'd0, (!to && ld && regwr)});
      if (!to) begin
        check("done_rw", {59'd0, wb_rw}, {59'd0, rw});
        check("done_data", {32'd0, wb_data},
              {32'd0, (ld ? rdata : res)});
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_result = 0; in_busB = 0; in_rw = 0;
    in_RegWr = 0; in_MemWr = 0; in_MemtoReg = 0;
    dm_rdata = 0; dm_ack = 0;
    tick();
    tick();
    check("rst_outs",
          {dm_req, dm_we, stall, wb_valid, wb_RegWr, wb_err, wb_rw},
          64'd0);
    check("rst_addr", {dm_addr, dm_wdata}, 64'd0);
    check("rst_data", {32'd0, wb_data}, 64'd0);
    rst = 1'b0;

    run_op(1, 32'h1234, 32'h0, 5'd8, 1'b1, 0, 32'h0);
    run_op(2, 32'h40, 32'h0, 5'd3, 1'b1, 3, 32'hDEADBEEF);
    run_op(3, 32'h44, 32'h55AA, 5'd9, 1'b1, 1, 32'h0);
    run_op(2, 32'h80, 32'h0, 5'd4, 1'b1, MAXW + 1, 32'h0);
    run_op(2, 32'h84, 32'h0, 5'd5, 1'b1, MAXW, 32'hCAFEF00D);
    run_op(2, 32'h42, 32'h0, 5'd6, 1'b1, 2, 32'h600D);

    // reset while waiting on memory
    in_valid = 1; in_MemtoReg = 1; in_MemWr = 0;
    in_result = 32'h100; in_RegWr = 1; in_rw = 5'd7;
    tick();
    in_valid = 0;
    tick();
    tick();
    check("midw_stall", {63'd0, stall}, 64'd1);
    rst = 1'b1;
    tick();
    check("midw_req", {63'd0, dm_req}, 64'd0);
    check("midw_stall0", {63'd0, stall}, 64'd0);
    check("midw_wb",
          {wb_valid, wb_RegWr, wb_err, wb_rw, wb_data}, 64'd0);
    rst = 1'b0;
    tick();
    check("midw_idle", {63'd0, wb_valid}, 64'd0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 1) == 0) r[1:0] = 2'b00;
      run_op($urandom_range(0, 3), r, $urandom,
             5'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(1, MAXW + 2), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
